// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator: it moves a registered PWM duty value toward a
// commanded target in fixed steps. Each step is separated by a programmable cycle interval.
module pwm_duty_ramp #(
    parameter int unsigned R = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [R:0]    target,
    input  logic [R:0]    step,
    input  logic [31:0]   interval,
    input  logic          abort,
    output logic [R:0]    duty,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [R:0] FULL_SCALE = {1'b1, {R{1'b0}}};
    localparam logic [R:0] ONE_STEP   = {{R{1'b0}}, 1'b1};

    state_t        r_state;
    logic [R:0]    r_duty;
    logic [R:0]    r_target;
    logic [R:0]    r_step;
    logic [31:0]   r_interval;
    logic [31:0]   r_cnt;
    logic          r_done;
    logic          r_busy;
    logic          r_ready;

    logic [R:0]    w_tgt_clamp;
    logic [R:0]    w_step_fix;
    logic [R+1:0]  w_up_sum;
    logic          w_up_hit;
    logic [R+1:0]  w_dn_limit;
    logic          w_dn_hit;
    logic          w_tick;

    // Command conditioning: saturate the target to full scale, promote a zero step to one
    always_comb begin
        w_tgt_clamp = target;
        w_step_fix  = step;
        if (target > FULL_SCALE) begin
            w_tgt_clamp = FULL_SCALE;
        end else begin
            w_tgt_clamp = target;
        end
        if (step == {(R+1){1'b0}}) begin
            w_step_fix = ONE_STEP;
        end else begin
            w_step_fix = step;
        end
    end

    // Step arithmetic is one bit wider so neither direction can wrap around
    always_comb begin
        w_up_sum   = {1'b0, r_duty} + {1'b0, r_step};
        w_up_hit   = (w_up_sum >= {1'b0, r_target});
        w_dn_limit = {1'b0, r_target} + {1'b0, r_step};
        w_dn_hit   = ({1'b0, r_duty} <= w_dn_limit);
        w_tick     = (r_cnt == r_interval);
    end

    // Ramp state machine with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_duty     <= {(R+1){1'b0}};
            r_target   <= {(R+1){1'b0}};
            r_step     <= {(R+1){1'b0}};
            r_interval <= 32'd0;
            r_cnt      <= 32'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_target   <= w_tgt_clamp;
                        r_step     <= w_step_fix;
                        r_interval <= interval;
                        r_cnt      <= 32'd0;
                        if (w_tgt_clamp > r_duty) begin
                            r_state <= UP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else if (w_tgt_clamp < r_duty) begin
                            r_state <= DOWN;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                UP: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (w_tick) begin
                        r_cnt <= 32'd0;
                        if (w_up_hit) begin
                            r_duty  <= r_target;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_duty <= w_up_sum[R:0];
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                DOWN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (w_tick) begin
                        r_cnt <= 32'd0;
                        // Compare first: subtracting only when it stays above target
                        if (w_dn_hit) begin
                            r_duty  <= r_target;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_duty <= r_duty - r_step;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign duty      = r_duty;
    assign busy      = r_busy;
    assign cmd_ready = r_ready;
    assign done      = r_done;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp (R = 10); expected duty trajectories are
// hand-derived per scenario and sampled on the falling clock edge.
module tb_pwm_duty_ramp;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] target;
    logic [10:0] step;
    logic [31:0] interval;
    logic        abort;
    logic [10:0] duty;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    pwm_duty_ramp #(.R(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .target    (target),
        .step      (step),
        .interval  (interval),
        .abort     (abort),
        .duty      (duty),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Called at a falling edge; returns at the falling edge just after the accept edge
    task automatic send_cmd(input int t, input int s, input int iv);
        cmd_valid = 1'b1;
        target    = 11'(t);
        step      = 11'(s);
        interval  = 32'(iv);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int exp_d;
        rst = 1'b1; cmd_valid = 1'b0; target = 11'd0; step = 11'd0;
        interval = 32'd0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_duty",  32'(duty), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Ramp up 0 -> 100, step 10, interval 4
        send_cmd(100, 10, 4);
        check_val("up_busy0",  32'(busy), 32'd1);
        check_val("up_ready0", 32'(cmd_ready), 32'd0);
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            exp_d = (k / 5) * 10;
            if (exp_d > 100) exp_d = 100;
            check_val("up_duty", 32'(duty), 32'(exp_d));
            check_val("up_done", 32'(done), (k == 50) ? 32'd1 : 32'd0);
            check_val("up_busy", 32'(busy), (k < 50) ? 32'd1 : 32'd0);
        end
        check_val("up_ready_end", 32'(cmd_ready), 32'd1);

        // Overshoot clamp 100 -> 105 with step 10
        send_cmd(105, 10, 0);
        @(negedge clk);
        check_val("ovs_duty", 32'(duty), 32'd105);
        check_val("ovs_done", 32'(done), 32'd1);
        check_val("ovs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("ovs_hold", 32'(duty), 32'd105);
        check_val("ovs_done_clr", 32'(done), 32'd0);

        // Jump to full scale, then ramp down by 300
        send_cmd(1024, 1024, 0);
        @(negedge clk);
        check_val("full_duty", 32'(duty), 32'd1024);
        check_val("full_done", 32'(done), 32'd1);
        send_cmd(0, 300, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_d = (k == 4) ? 0 : 1024 - 300 * k;
            check_val("dn_duty", 32'(duty), 32'(exp_d));
            check_val("dn_done", 32'(done), (k == 4) ? 32'd1 : 32'd0);
        end

        // Target clamp 2000 -> 1024 from 1020 with step 0 (acts as 1)
        send_cmd(1020, 1020, 0);
        @(negedge clk);
        check_val("pre_clamp", 32'(duty), 32'd1020);
        send_cmd(2000, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_d = (k >= 4) ? 1024 : 1020 + k;
            check_val("clamp_duty", 32'(duty), 32'(exp_d));
            check_val("clamp_done", 32'(done), (k == 4) ? 32'd1 : 32'd0);
        end
        // Clamped target equal to duty: done on the cycle after accept, no ramp
        send_cmd(2000, 5, 3);
        check_val("eq_done", 32'(done), 32'd1);
        check_val("eq_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("eq_done_clr", 32'(done), 32'd0);
        check_val("eq_duty", 32'(duty), 32'd1024);

        // Back to 0, then abort after three steps with an ignored command
        send_cmd(0, 1024, 0);
        @(negedge clk);
        check_val("zero_duty", 32'(duty), 32'd0);
        send_cmd(500, 50, 9);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            exp_d = (k >= 30) ? 150 : (k / 10) * 50;
            check_val("ab_duty", 32'(duty), 32'(exp_d));
            check_val("ab_done", 32'(done), 32'd0);
            check_val("ab_busy", 32'(busy), (k < 31) ? 32'd1 : 32'd0);
            if (k == 5) begin
                cmd_valid = 1'b1; target = 11'd7; step = 11'd1; interval = 32'd0;
            end else begin
                cmd_valid = 1'b0;
            end
            if (k == 30) abort = 1'b1;
        end
        abort = 1'b0;
        check_val("ab_ready", 32'(cmd_ready), 32'd1);

        // New ramp from 150; abort coincides with the completing step
        send_cmd(200, 50, 2);
        check_val("col_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("col_duty1", 32'(duty), 32'd150);
        @(negedge clk);
        check_val("col_duty2", 32'(duty), 32'd150);
        abort = 1'b1;
        @(negedge clk);
        check_val("col_duty3", 32'(duty), 32'd150);
        check_val("col_done",  32'(done), 32'd0);
        check_val("col_busy",  32'(busy), 32'd0);
        @(negedge clk);
        check_val("idle_abort_duty", 32'(duty), 32'd150);
        check_val("idle_abort_rdy",  32'(cmd_ready), 32'd1);
        abort = 1'b0;
        send_cmd(200, 50, 0);
        check_val("from150_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_val("from150_duty", 32'(duty), 32'd200);
        check_val("from150_done", 32'(done), 32'd1);

        // Reset pulse mid-ramp, between clock edges
        send_cmd(1000, 1, 0);
        repeat (3) @(negedge clk);
        check_val("mid_duty", 32'(duty), 32'd203);
        #1 rst = 1'b1;
        #1;
        check_val("arst_duty",  32'(duty), 32'd0);
        check_val("arst_busy",  32'(busy), 32'd0);
        check_val("arst_done",  32'(done), 32'd0);
        check_val("arst_ready", 32'(cmd_ready), 32'd1);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("post_rst_done", 32'(done), 32'd0);
            check_val("post_rst_duty", 32'(duty), 32'd0);
        end
        send_cmd(30, 10, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_val("post_rst_ramp", 32'(duty), 32'((k / 2) * 10));
            check_val("post_rst_rdone", 32'(done), (k == 6) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
